rocket_launch_controller: RTL and testbench
===========================================

// Module: rocket_launch_controller
// PURPOSE
// - Upstream of the single-rocket motion controller. Turns the player's fire button into one launch of the
//   player rocket: latches launch X/Y/speed, drives the rocket's active flag, retires it on border/hit,
//   then enforces a frame-counted cooldown before the next shot. Instantiated once per player rocket.
// PARAMETERS
// - X_OFFSET        16   pixels added to playerX to centre the rocket on the ship
// - ROCKET_HEIGHT   32   pixels subtracted from playerY so the rocket spawns above the ship
// - ROCKET_SPEED    256  launch speed magnitude, (pixels/64) per frame; issued as -ROCKET_SPEED (upward)
// - COOLDOWN_FRAMES 8    startOfFrame pulses to wait after retirement before re-arming (1..255)
// - GUARD_CYCLES    2    clk cycles after rocketActive rises during which reachedBorder/hit are ignored
// PORTS
// - clk            in   1    system clock
// - reset          in   1    synchronous, active-high reset
// - startOfFrame   in   1    one-clk pulse per frame
// - fireButton     in   1    level from keypad decoder, already synchronised to clk
// - playerX        in   11s  player top-left X
// - playerY        in   11s  player top-left Y
// - reachedBorder  in   1    from motion controller
// - rocketHit      in   1    one-clk pulse from collision logic
// - rocketActive   out  1    to motion controller isActive
// - initialX       out  11s  launch X, registered
// - initialY       out  11s  launch Y, registered
// - initialSpeed   out  11s  launch speed, registered
// - readyToFire    out  1    high in IDLE only
// - shotCount      out  8    launches issued, wraps 255->0
// BEHAVIOUR
// - Clock/reset: one clock clk; reset is synchronous, active-high. Reset: state IDLE, rocketActive=0,
//   initialX=0, initialY=0, initialSpeed=0, readyToFire=1 after reset deasserts, shotCount=0,
//   counters 0, fire edge register 0. Reset mid-flight drops rocketActive on the next edge.
// - fireRise = fireButton & !fireButton_d (registered previous value).
// - FSM:
//   IDLE:     readyToFire=1. fireRise -> ARM; latch initialX=playerX+X_OFFSET,
//             initialY=playerY-ROCKET_HEIGHT, initialSpeed=-ROCKET_SPEED; shotCount++.
//   ARM:      one cycle, rocketActive=0 with launch values already stable -> FLIGHT.
//   FLIGHT:   rocketActive=1. guardCnt counts GUARD_CYCLES; reachedBorder/rocketHit ignored while counting
//             (downstream Y is stale for one cycle after its isActive rise). After guard,
//             reachedBorder|rocketHit -> COOLDOWN; rocketActive low from the next cycle.
//   COOLDOWN: rocketActive=0; count startOfFrame pulses; on the COOLDOWN_FRAMES-th pulse -> IDLE.
// - Latency: fireRise at edge N -> rocketActive=1 at edge N+2; launch values stable from edge N+1.
// - Launch values held constant outside IDLE->ARM; playerX/Y changes mid-flight have no effect.
// - Fire presses outside IDLE are dropped, never queued; held button does not re-fire.
// - Border and hit in the same cycle: a single retirement.
// - startOfFrame on the retirement cycle is not counted.
// - Arithmetic: 11-bit signed, wraps silently; offsets are not clamped to screen.
// CONFIGURATION
// - AUTOFIRE_EN defined: in IDLE, a fireButton level held high (not only fireRise) launches, so a held button
//   fires again as soon as cooldown ends.
// - AUTOFIRE_EN undefined: only fireRise launches.
// TESTING
// - Reset, then playerX=100, playerY=400, fire 0->1 -> ARM: initialX=116, initialY=368, initialSpeed=-256;
//   rocketActive=1 two clks later; shotCount=1.
// - reachedBorder=1 in first FLIGHT cycle -> ignored, rocketActive stays 1.
// - reachedBorder=1 in the 3rd FLIGHT cycle -> rocketActive=0 next clk.
// - Retire by rocketHit, 8 startOfFrame pulses -> readyToFire=1 after the 8th only.
// - Fire rises during FLIGHT and COOLDOWN -> no relaunch and no shotCount change.
// - Button held through cooldown -> no relaunch (AUTOFIRE_EN: relaunch one clk after IDLE).
// - reset=1 mid-FLIGHT -> next clk rocketActive=0, shotCount=0, state IDLE.
// - 256 launches -> shotCount wraps to 0.

Source files
------------

// File: rtl/rocket_launch_if.sv
// Bundle between the player-input side and the rocket launch controller.
// The master drives fire/player/feedback inputs; the slave returns the launch values and status.
interface rocket_launch_if;
    logic               startOfFrame;
    logic               fireButton;
    logic signed [10:0] playerX;
    logic signed [10:0] playerY;
    logic               reachedBorder;
    logic               rocketHit;
    logic               rocketActive;
    logic signed [10:0] initialX;
    logic signed [10:0] initialY;
    logic signed [10:0] initialSpeed;
    logic               readyToFire;
    logic [7:0]         shotCount;

    modport master (
        output startOfFrame, fireButton, playerX, playerY, reachedBorder, rocketHit,
        input  rocketActive, initialX, initialY, initialSpeed, readyToFire, shotCount
    );

    modport slave (
        input  startOfFrame, fireButton, playerX, playerY, reachedBorder, rocketHit,
        output rocketActive, initialX, initialY, initialSpeed, readyToFire, shotCount
    );
endinterface

// File: rtl/rocket_launch_controller.sv
// Turns the fire button into a single player-rocket launch, retires it on border/hit, then waits a
// frame-counted cooldown. Define AUTOFIRE_EN to let a held button launch again once cooldown ends.
module rocket_launch_controller #(
    parameter int X_OFFSET        = 16,
    parameter int ROCKET_HEIGHT   = 32,
    parameter int ROCKET_SPEED    = 256,
    parameter int COOLDOWN_FRAMES = 8,
    parameter int GUARD_CYCLES    = 2
) (
    input  logic            clk,
    input  logic            reset,
    rocket_launch_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARM      = 2'd1,
        FLIGHT   = 2'd2,
        COOLDOWN = 2'd3
    } state_e;

    localparam logic signed [10:0] X_OFF_C        = 11'(X_OFFSET);
    localparam logic signed [10:0] Y_OFF_C        = 11'(ROCKET_HEIGHT);
    localparam logic signed [10:0] LAUNCH_SPEED_C = 11'(-ROCKET_SPEED);
    localparam logic [7:0]         CD_LAST_C      = 8'(COOLDOWN_FRAMES - 1);
    localparam logic [7:0]         GUARD_LIM_C    = 8'(GUARD_CYCLES);

    state_e             state_q, state_d;
    logic               fire_prev_q, fire_prev_d;
    logic               rocket_active_q, rocket_active_d;
    logic               ready_q, ready_d;
    logic signed [10:0] init_x_q, init_x_d;
    logic signed [10:0] init_y_q, init_y_d;
    logic signed [10:0] init_speed_q, init_speed_d;
    logic [7:0]         shot_cnt_q, shot_cnt_d;
    logic [7:0]         guard_cnt_q, guard_cnt_d;
    logic [7:0]         cd_cnt_q, cd_cnt_d;

    logic fire_rise_s;
    logic launch_s;
    logic retire_s;

    // Next-state, launch latching, guard and cooldown counting.
    always_comb begin
        state_d         = state_q;
        fire_prev_d     = bus.fireButton;
        rocket_active_d = 1'b0;
        init_x_d        = init_x_q;
        init_y_d        = init_y_q;
        init_speed_d    = init_speed_q;
        shot_cnt_d      = shot_cnt_q;
        guard_cnt_d     = guard_cnt_q;
        cd_cnt_d        = cd_cnt_q;

        fire_rise_s = bus.fireButton & ~fire_prev_q;
`ifdef AUTOFIRE_EN
        launch_s    = bus.fireButton;
`else
        launch_s    = fire_rise_s;
`endif
        // Guard is counted from the visible rocketActive rise: downstream Y is stale just after it.
        retire_s = rocket_active_q && (guard_cnt_q == GUARD_LIM_C)
                   && (bus.reachedBorder || bus.rocketHit);

        case (state_q)
            IDLE: begin
                if (launch_s) begin
                    state_d      = ARM;
                    init_x_d     = bus.playerX + X_OFF_C;
                    init_y_d     = bus.playerY - Y_OFF_C;
                    init_speed_d = LAUNCH_SPEED_C;
                    shot_cnt_d   = shot_cnt_q + 8'd1;
                end else begin
                    state_d      = IDLE;
                end
            end
            ARM: begin
                state_d     = FLIGHT;
                guard_cnt_d = 8'd0;
            end
            FLIGHT: begin
                if (retire_s) begin
                    state_d         = COOLDOWN;
                    cd_cnt_d        = 8'd0;
                    rocket_active_d = 1'b0;
                end else begin
                    rocket_active_d = 1'b1;
                    if (rocket_active_q && (guard_cnt_q < GUARD_LIM_C)) begin
                        guard_cnt_d = guard_cnt_q + 8'd1;
                    end else begin
                        guard_cnt_d = guard_cnt_q;
                    end
                end
            end
            COOLDOWN: begin
                if (bus.startOfFrame) begin
                    if (cd_cnt_q == CD_LAST_C) begin
                        state_d  = IDLE;
                        cd_cnt_d = 8'd0;
                    end else begin
                        cd_cnt_d = cd_cnt_q + 8'd1;
                    end
                end else begin
                    cd_cnt_d = cd_cnt_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            fire_prev_q     <= 1'b0;
            rocket_active_q <= 1'b0;
            ready_q         <= 1'b1;
            init_x_q        <= 11'sd0;
            init_y_q        <= 11'sd0;
            init_speed_q    <= 11'sd0;
            shot_cnt_q      <= 8'd0;
            guard_cnt_q     <= 8'd0;
            cd_cnt_q        <= 8'd0;
        end else begin
            state_q         <= state_d;
            fire_prev_q     <= fire_prev_d;
            rocket_active_q <= rocket_active_d;
            ready_q         <= ready_d;
            init_x_q        <= init_x_d;
            init_y_q        <= init_y_d;
            init_speed_q    <= init_speed_d;
            shot_cnt_q      <= shot_cnt_d;
            guard_cnt_q     <= guard_cnt_d;
            cd_cnt_q        <= cd_cnt_d;
        end
    end

    assign bus.rocketActive = rocket_active_q;
    assign bus.readyToFire  = ready_q;
    assign bus.initialX     = init_x_q;
    assign bus.initialY     = init_y_q;
    assign bus.initialSpeed = init_speed_q;
    assign bus.shotCount    = shot_cnt_q;

endmodule

// File: tb/tb_rocket_launch_controller.sv
// Randomised and directed bench for rocket_launch_controller against a timeline-based launch model.
module tb_rocket_launch_controller;

    localparam int X_OFFSET        = 16;
    localparam int ROCKET_HEIGHT   = 32;
    localparam int ROCKET_SPEED    = 256;
    localparam int COOLDOWN_FRAMES = 8;
    localparam int GUARD_CYCLES    = 2;
`ifdef AUTOFIRE_EN
    localparam bit AUTOFIRE = 1'b1;
`else
    localparam bit AUTOFIRE = 1'b0;
`endif

    logic clk;
    logic reset;
    rocket_launch_if bus ();

    rocket_launch_controller #(
        .X_OFFSET        (X_OFFSET),
        .ROCKET_HEIGHT   (ROCKET_HEIGHT),
        .ROCKET_SPEED    (ROCKET_SPEED),
        .COOLDOWN_FRAMES (COOLDOWN_FRAMES),
        .GUARD_CYCLES    (GUARD_CYCLES)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: a launch is a point on the edge timeline; everything else is derived from it.
    int                 cyc       = 0;
    bit                 m_busy    = 1'b0;
    int                 m_launch  = 0;
    int                 m_retire  = -1;
    int                 m_frames  = 0;
    bit                 m_prev    = 1'b0;
    logic signed [10:0] m_x       = 11'sd0;
    logic signed [10:0] m_y       = 11'sd0;
    logic signed [10:0] m_spd     = 11'sd0;
    int                 m_shots   = 0;
    bit                 m_active  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model update on each edge, then compare just after the edge.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (reset) begin
                m_busy = 1'b0; m_retire = -1; m_frames = 0; m_prev = 1'b0;
                m_x = 11'sd0; m_y = 11'sd0; m_spd = 11'sd0; m_shots = 0;
            end else begin
                if (!m_busy) begin
                    if (bus.fireButton && (AUTOFIRE || !m_prev)) begin
                        m_busy   = 1'b1;
                        m_launch = cyc;
                        m_retire = -1;
                        m_x      = 11'(int'(bus.playerX) + X_OFFSET);
                        m_y      = 11'(int'(bus.playerY) - ROCKET_HEIGHT);
                        m_spd    = 11'(-ROCKET_SPEED);
                        m_shots  = (m_shots + 1) % 256;
                    end
                end else if (m_retire < 0) begin
                    if (cyc >= m_launch + 2 + GUARD_CYCLES + 1 && (bus.reachedBorder || bus.rocketHit)) begin
                        m_retire = cyc;
                        m_frames = 0;
                    end
                end else if (bus.startOfFrame) begin
                    m_frames++;
                    if (m_frames == COOLDOWN_FRAMES) m_busy = 1'b0;
                end
                m_prev = bus.fireButton;
            end
            m_active = m_busy && (m_retire < 0) && (cyc >= m_launch + 2);
            #1;
            chk("rocketActive", 32'(bus.rocketActive), 32'(m_active));
            chk("readyToFire",  32'(bus.readyToFire),  32'(!m_busy));
            chk("initialX",     32'(bus.initialX),     32'(m_x));
            chk("initialY",     32'(bus.initialY),     32'(m_y));
            chk("initialSpeed", 32'(bus.initialSpeed), 32'(m_spd));
            chk("shotCount",    32'(bus.shotCount),    32'(m_shots));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.fireButton = 1'b0; bus.startOfFrame = 1'b0;
        bus.reachedBorder = 1'b0; bus.rocketHit = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        bus.playerX = 11'sd100;
        bus.playerY = 11'sd400;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("reset_ready", 32'(bus.readyToFire), 32'd1);
        chk("reset_shots", 32'(bus.shotCount), 32'd0);

        // First launch from (100,400), button then held.
        bus.fireButton = 1'b1;
        tick();
        chk("lit_x",      32'(bus.initialX), 32'd116);
        chk("lit_y",      32'(bus.initialY), 32'd368);
        chk("lit_speed",  32'(bus.initialSpeed), 32'hFFFF_FF00);
        chk("lit_shots",  32'(bus.shotCount), 32'd1);
        chk("model_x",    32'(m_x), 32'd116);
        chk("model_y",    32'(m_y), 32'd368);
        chk("lit_arm_inactive", 32'(bus.rocketActive), 32'd0);
        bus.playerX = 11'sd5;
        tick();
        chk("lit_n1_inactive", 32'(bus.rocketActive), 32'd0);
        tick();
        chk("lit_n2_active", 32'(bus.rocketActive), 32'd1);
        bus.reachedBorder = 1'b1;
        tick();
        chk("lit_guard_ignored", 32'(bus.rocketActive), 32'd1);
        bus.reachedBorder = 1'b0;
        tick();
        bus.reachedBorder = 1'b1;
        bus.fireButton = 1'b0;
        tick();
        chk("lit_border_retire", 32'(bus.rocketActive), 32'd0);
        bus.reachedBorder = 1'b0;
        bus.fireButton = 1'b1;
        tick();
        bus.fireButton = 1'b0;
        tick();
        bus.fireButton = 1'b1;
        for (int k = 1; k <= COOLDOWN_FRAMES; k++) begin
            bus.startOfFrame = 1'b1;
            tick();
            bus.startOfFrame = 1'b0;
            chk("lit_cooldown_ready", 32'(bus.readyToFire), (k == COOLDOWN_FRAMES) ? 32'd1 : 32'd0);
            tick();
        end
        chk("lit_no_relaunch_shots", 32'(m_shots), AUTOFIRE ? 32'd2 : 32'd1);
        repeat (4) tick();

        // Reset in the middle of a flight.
        clear_inputs();
        reset = 1'b1; tick(); reset = 1'b0; tick();
        bus.fireButton = 1'b1;
        repeat (4) tick();
        chk("lit_pre_reset_active", 32'(bus.rocketActive), 32'd1);
        reset = 1'b1;
        tick();
        chk("lit_reset_active", 32'(bus.rocketActive), 32'd0);
        chk("lit_reset_shots",  32'(bus.shotCount), 32'd0);
        chk("lit_reset_ready",  32'(bus.readyToFire), 32'd1);
        reset = 1'b0;
        bus.fireButton = 1'b0;

        // Random phase.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 5) == 0) bus.fireButton = ~bus.fireButton;
            bus.reachedBorder = ($urandom_range(0, 7) == 0);
            bus.rocketHit     = ($urandom_range(0, 9) == 0);
            bus.startOfFrame  = ($urandom_range(0, 2) == 0);
            bus.playerX       = 11'($urandom);
            bus.playerY       = 11'($urandom);
            reset             = ($urandom_range(0, 399) == 0);
            tick();
        end

        // 256 launches retired by hit: shot counter wraps to zero.
        clear_inputs();
        reset = 1'b1; tick(); reset = 1'b0; tick();
        for (int n = 0; n < 256; n++) begin
            bus.fireButton = 1'b1; tick();
            bus.fireButton = 1'b0; repeat (6) tick();
            bus.rocketHit = 1'b1; tick();
            bus.rocketHit = 1'b0;
            for (int k = 0; k < COOLDOWN_FRAMES; k++) begin
                bus.startOfFrame = 1'b1; tick();
                bus.startOfFrame = 1'b0; tick();
            end
            tick();
        end
        chk("lit_wrap_shots",  32'(bus.shotCount), 32'd0);
        chk("model_wrap",      32'(m_shots), 32'd0);
        chk("lit_wrap_ready",  32'(bus.readyToFire), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
